// File: rtl/rv_exec_unit.sv
// ---------------------------------------------------------------------------
// rv_exec_unit
//
// RV32I execute stage for the single-cycle datapath. This block combines four
// pieces of logic: the ALU-control decode, a 32-bit ALU, the PC+4 adder and
// the branch-target adder. Every result is captured in a register, so outputs
// appear one cycle after their inputs are sampled.
//
// Ports
//   clockDP       in   1     clock; all state updates on the rising edge
//   resetDP       in   1     synchronous, active-low reset
//   pcIn          in   XLEN  current PC
//   immIn         in   XLEN  sign-extended immediate (byte offset, unshifted)
//   rs1Data       in   XLEN  register read port 1 (operand A)
//   rs2Data       in   XLEN  register read port 2
//   aluSrc        in   1     0: operand B = rs2Data, 1: operand B = immIn
//   aluOp         in   2     00 add, 01 sub/branch, 10 R-type, 11 I-type ALU
//   f3f7          in   4     {instr[30], instr[14:12]}
//   branch        in   1     BEQ branch flag from control
//   aluResult     out  XLEN  registered ALU result
//   aluZero       out  1     registered (aluResult == 0)
//   pcPlus4       out  XLEN  registered pcIn + PC_STEP
//   branchTarget  out  XLEN  registered pcIn + immIn
//   takeBranch    out  1     registered branch & zero
//   nextPc        out  XLEN  registered takeBranch ? branchTarget : pcPlus4
// ---------------------------------------------------------------------------
module rv_exec_unit #(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] PC_STEP = 4
) (
    input  logic            clockDP,
    input  logic            resetDP,
    input  logic [XLEN-1:0] pcIn,
    input  logic [XLEN-1:0] immIn,
    input  logic [XLEN-1:0] rs1Data,
    input  logic [XLEN-1:0] rs2Data,
    input  logic            aluSrc,
    input  logic [1:0]      aluOp,
    input  logic [3:0]      f3f7,
    input  logic            branch,
    output logic [XLEN-1:0] aluResult,
    output logic            aluZero,
    output logic [XLEN-1:0] pcPlus4,
    output logic [XLEN-1:0] branchTarget,
    output logic            takeBranch,
    output logic [XLEN-1:0] nextPc
);

    // ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // aluOp encodings from the main control unit
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_ITYPE = 2'b11;

    // funct3 encodings shared by R-type and I-type ALU instructions
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    logic [2:0]      funct3;
    logic            alt_bit;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_out;
    logic            alu_zero;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] branch_tgt;
    logic            take_br;

    // Registered outputs
    logic [XLEN-1:0] alu_result_q,    alu_result_d;
    logic            alu_zero_q,      alu_zero_d;
    logic [XLEN-1:0] pc_plus4_q,      pc_plus4_d;
    logic [XLEN-1:0] branch_target_q, branch_target_d;
    logic            take_branch_q,   take_branch_d;
    logic [XLEN-1:0] next_pc_q,       next_pc_d;

    assign funct3  = f3f7[2:0];
    assign alt_bit = f3f7[3];

    // -----------------------------------------------------------------------
    // ALU control decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path through the case statements can infer a latch.
        alu_ctrl = ALU_ADD;
        case (aluOp)
            OP_ADD: alu_ctrl = ALU_ADD;
            OP_SUB: alu_ctrl = ALU_SUB;
            OP_RTYPE, OP_ITYPE: begin
                case (funct3)
                    // instr[30] selects SUB only for R-type; ADDI has a real
                    // immediate bit there that must not flip the operation.
                    F3_ADD:  alu_ctrl = (aluOp == OP_RTYPE && alt_bit) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  alu_ctrl = ALU_SLL;
                    F3_SLT:  alu_ctrl = ALU_SLT;
                    F3_SLTU: alu_ctrl = ALU_SLTU;
                    F3_XOR:  alu_ctrl = ALU_XOR;
                    // SRAI keeps instr[30] in its encoding, so it is honoured
                    // for both R-type and I-type shifts.
                    F3_SR:   alu_ctrl = alt_bit ? ALU_SRA : ALU_SRL;
                    F3_OR:   alu_ctrl = ALU_OR;
                    F3_AND:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    // -----------------------------------------------------------------------
    // ALU
    // -----------------------------------------------------------------------
    assign op_a  = rs1Data;
    assign op_b  = aluSrc ? immIn : rs2Data;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            ALU_AND:  alu_out = op_a & op_b;
            ALU_OR:   alu_out = op_a | op_b;
            ALU_ADD:  alu_out = op_a + op_b;
            ALU_XOR:  alu_out = op_a ^ op_b;
            ALU_SLL:  alu_out = op_a << shamt;
            ALU_SRL:  alu_out = op_a >> shamt;
            ALU_SUB:  alu_out = op_a - op_b;
            ALU_SRA:  alu_out = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:  alu_out = '0;
        endcase
    end

    assign alu_zero = (alu_out == '0);

    // -----------------------------------------------------------------------
    // PC adders and branch resolution
    // -----------------------------------------------------------------------
    assign pc_plus4   = pcIn + PC_STEP;
    assign branch_tgt = pcIn + immIn;
    assign take_br    = branch & alu_zero;

    // Next-state values for the output registers
    always_comb begin
        alu_result_d    = alu_out;
        alu_zero_d      = alu_zero;
        pc_plus4_d      = pc_plus4;
        branch_target_d = branch_tgt;
        take_branch_d   = take_br;
        next_pc_d       = take_br ? branch_tgt : pc_plus4;
    end

    // -----------------------------------------------------------------------
    // Output registers; reset wins over new data in the same cycle
    // -----------------------------------------------------------------------
    always_ff @(posedge clockDP) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples its _d value from before this edge, independent of order.
        if (!resetDP) begin
            alu_result_q    <= '0;
            alu_zero_q      <= 1'b0;
            pc_plus4_q      <= '0;
            branch_target_q <= '0;
            take_branch_q   <= 1'b0;
            next_pc_q       <= '0;
        end else begin
            alu_result_q    <= alu_result_d;
            alu_zero_q      <= alu_zero_d;
            pc_plus4_q      <= pc_plus4_d;
            branch_target_q <= branch_target_d;
            take_branch_q   <= take_branch_d;
            next_pc_q       <= next_pc_d;
        end
    end

    assign aluResult    = alu_result_q;
    assign aluZero      = alu_zero_q;
    assign pcPlus4      = pc_plus4_q;
    assign branchTarget = branch_target_q;
    assign takeBranch   = take_branch_q;
    assign nextPc       = next_pc_q;

endmodule

// File: tb/tb_rv_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_rv_exec_unit
//
// Self-checking bench for rv_exec_unit. Each test task drives one input vector
// per cycle and pushes the expected registered outputs onto a scoreboard
// queue. A monitor pops one entry shortly after every rising edge and compares
// all six outputs against it.
// ---------------------------------------------------------------------------
module tb_rv_exec_unit;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic        zero;
        logic [31:0] pc_plus4;
        logic [31:0] target;
        logic        take;
        logic [31:0] next_pc;
    } exp_t;

    logic        clockDP;
    logic        resetDP;
    logic [31:0] pcIn;
    logic [31:0] immIn;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic        aluSrc;
    logic [1:0]  aluOp;
    logic [3:0]  f3f7;
    logic        branch;
    logic [31:0] aluResult;
    logic        aluZero;
    logic [31:0] pcPlus4;
    logic [31:0] branchTarget;
    logic        takeBranch;
    logic [31:0] nextPc;

    exp_t sb[$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;

    rv_exec_unit #(.XLEN(32), .PC_STEP(32'd4)) dut (
        .clockDP      (clockDP),
        .resetDP      (resetDP),
        .pcIn         (pcIn),
        .immIn        (immIn),
        .rs1Data      (rs1Data),
        .rs2Data      (rs2Data),
        .aluSrc       (aluSrc),
        .aluOp        (aluOp),
        .f3f7         (f3f7),
        .branch       (branch),
        .aluResult    (aluResult),
        .aluZero      (aluZero),
        .pcPlus4      (pcPlus4),
        .branchTarget (branchTarget),
        .takeBranch   (takeBranch),
        .nextPc       (nextPc)
    );

    initial clockDP = 1'b0;
    always #5 clockDP = ~clockDP;

    // Scoreboard consumer: one expectation per rising edge while queued.
    always begin
        @(posedge clockDP);
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            tests_run++;
            if (aluResult !== mon_e.result) begin
                tests_failed++;
                $display("FAIL %s aluResult got %h expected %h", mon_e.name, aluResult, mon_e.result);
            end
            tests_run++;
            if (aluZero !== mon_e.zero) begin
                tests_failed++;
                $display("FAIL %s aluZero got %b expected %b", mon_e.name, aluZero, mon_e.zero);
            end
            tests_run++;
            if (pcPlus4 !== mon_e.pc_plus4) begin
                tests_failed++;
                $display("FAIL %s pcPlus4 got %h expected %h", mon_e.name, pcPlus4, mon_e.pc_plus4);
            end
            tests_run++;
            if (branchTarget !== mon_e.target) begin
                tests_failed++;
                $display("FAIL %s branchTarget got %h expected %h", mon_e.name, branchTarget, mon_e.target);
            end
            tests_run++;
            if (takeBranch !== mon_e.take) begin
                tests_failed++;
                $display("FAIL %s takeBranch got %b expected %b", mon_e.name, takeBranch, mon_e.take);
            end
            tests_run++;
            if (nextPc !== mon_e.next_pc) begin
                tests_failed++;
                $display("FAIL %s nextPc got %h expected %h", mon_e.name, nextPc, mon_e.next_pc);
            end
        end
    end

    // Drive one vector, queue its expectation, and advance past the edge.
    // The PC adders and nextPc are derived here from the driven pc/imm and the
    // expected branch decision; result/zero/take come from the caller.
    task automatic apply(input string name, input logic rst_n,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic [1:0] op,
                         input logic [3:0] ff, input logic br,
                         input logic [31:0] exp_res, input logic exp_zero,
                         input logic exp_take);
        exp_t e;
        resetDP = rst_n;
        pcIn    = pc;
        immIn   = imm;
        rs1Data = a;
        rs2Data = b;
        aluSrc  = src;
        aluOp   = op;
        f3f7    = ff;
        branch  = br;
        e.name = name;
        if (!rst_n) begin
            e.result   = 32'h0;
            e.zero     = 1'b0;
            e.pc_plus4 = 32'h0;
            e.target   = 32'h0;
            e.take     = 1'b0;
            e.next_pc  = 32'h0;
        end else begin
            e.result   = exp_res;
            e.zero     = exp_zero;
            e.pc_plus4 = pc + 32'd4;
            e.target   = pc + imm;
            e.take     = exp_take;
            e.next_pc  = exp_take ? (pc + imm) : (pc + 32'd4);
        end
        sb.push_back(e);
        @(posedge clockDP);
        #2;
    endtask

    task automatic test_reset();
        logic [31:0] a, b, pc, imm, sum;
        // Two edges held in reset with arbitrary inputs: outputs must stay 0.
        for (int i = 0; i < 2; i++) begin
            apply("reset_hold", 1'b0, $urandom, $urandom, $urandom, $urandom,
                  1'b0, 2'b00, 4'h0, 1'b1, 32'h0, 1'b0, 1'b0);
        end
        // First edge after release shows a computed ADD.
        a   = $urandom;
        b   = $urandom;
        pc  = $urandom;
        imm = $urandom;
        sum = a + b;
        apply("reset_release", 1'b1, pc, imm, a, b, 1'b0, 2'b00, 4'h0, 1'b0,
              sum, (sum == 32'h0), 1'b0);
    endtask

    task automatic test_rtype_add_sub();
        apply("r_add", 1'b1, 32'h100, 32'h0, 32'd7, 32'd9, 1'b0, 2'b10, 4'b0000, 1'b0,
              32'd16, 1'b0, 1'b0);
        apply("r_sub", 1'b1, 32'h104, 32'h0, 32'd7, 32'd9, 1'b0, 2'b10, 4'b1000, 1'b0,
              32'hFFFF_FFFE, 1'b0, 1'b0);
        apply("r_sub_zero", 1'b1, 32'h108, 32'h0, 32'd7, 32'd7, 1'b0, 2'b10, 4'b1000, 1'b0,
              32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_logic_shift();
        logic [31:0] a = 32'hF0F0_F0F0;
        logic [31:0] b = 32'h0000_FF04;
        apply("r_and", 1'b1, 32'h200, 32'h10, a, b, 1'b0, 2'b10, 4'b0111, 1'b0, 32'h0000_F000, 1'b0, 1'b0);
        apply("r_or",  1'b1, 32'h204, 32'h10, a, b, 1'b0, 2'b10, 4'b0110, 1'b0, 32'hF0F0_FFF4, 1'b0, 1'b0);
        apply("r_xor", 1'b1, 32'h208, 32'h10, a, b, 1'b0, 2'b10, 4'b0100, 1'b0, 32'hF0F0_0FF4, 1'b0, 1'b0);
        apply("r_sll", 1'b1, 32'h20C, 32'h10, a, b, 1'b0, 2'b10, 4'b0001, 1'b0, 32'h0F0F_0F00, 1'b0, 1'b0);
        apply("r_sra", 1'b1, 32'h210, 32'h10, a, b, 1'b0, 2'b10, 4'b1101, 1'b0, 32'hFF0F_0F0F, 1'b0, 1'b0);
        apply("r_srl", 1'b1, 32'h214, 32'h10, a, b, 1'b0, 2'b10, 4'b0101, 1'b0, 32'h0F0F_0F0F, 1'b0, 1'b0);
    endtask

    task automatic test_itype();
        apply("i_addi_bit30", 1'b1, 32'h300, 32'hFFFF_FFFC, 32'd100, 32'h5555_5555, 1'b1, 2'b11, 4'b1000, 1'b0,
              32'd96, 1'b0, 1'b0);
        apply("load_add", 1'b1, 32'h304, 32'hFFFF_FFFC, 32'd100, 32'h5555_5555, 1'b1, 2'b00, 4'b1000, 1'b0,
              32'd96, 1'b0, 1'b0);
        apply("i_srai", 1'b1, 32'h308, 32'h0000_0004, 32'hF0F0_F0F0, 32'h0, 1'b1, 2'b11, 4'b1101, 1'b0,
              32'hFF0F_0F0F, 1'b0, 1'b0);
        apply("i_srli", 1'b1, 32'h30C, 32'h0000_0004, 32'hF0F0_F0F0, 32'h0, 1'b1, 2'b11, 4'b0101, 1'b0,
              32'h0F0F_0F0F, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        apply("beq_taken", 1'b1, 32'h40, 32'hFFFF_FFF8, 32'd5, 32'd5, 1'b0, 2'b01, 4'b0000, 1'b1,
              32'h0, 1'b1, 1'b1);
        apply("beq_not_taken", 1'b1, 32'h40, 32'hFFFF_FFF8, 32'd5, 32'd6, 1'b0, 2'b01, 4'b0000, 1'b1,
              32'hFFFF_FFFF, 1'b0, 1'b0);
        // Equal operands but no branch: zero set, fall through.
        apply("sub_no_branch", 1'b1, 32'h40, 32'hFFFF_FFF8, 32'd5, 32'd5, 1'b0, 2'b01, 4'b0111, 1'b0,
              32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_slt_wrap();
        apply("r_slt", 1'b1, 32'h500, 32'h0, 32'hFFFF_FFFF, 32'd1, 1'b0, 2'b10, 4'b0010, 1'b0,
              32'h1, 1'b0, 1'b0);
        apply("r_sltu", 1'b1, 32'h504, 32'h0, 32'hFFFF_FFFF, 32'd1, 1'b0, 2'b10, 4'b0011, 1'b0,
              32'h0, 1'b1, 1'b0);
        apply("pc_wrap", 1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 32'd1, 32'd2, 1'b0, 2'b00, 4'h0, 1'b0,
              32'd3, 1'b0, 1'b0);
        apply("add_wrap", 1'b1, 32'h508, 32'h0, 32'hFFFF_FFFF, 32'd1, 1'b0, 2'b00, 4'h0, 1'b1,
              32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        // Random ADD/SUB stream with a mid-stream reset in the middle.
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 4) begin
                apply("mid_reset", 1'b0, 32'h600, 32'h20, a, b, 1'b0, 2'b00, 4'h0, 1'b0,
                      32'h0, 1'b0, 1'b0);
            end else if (i[0]) begin
                apply("b2b_sub", 1'b1, 32'h600 + 32'(i * 4), 32'h20, a, b, 1'b0, 2'b01, 4'h0, 1'b0,
                      a - b, (a == b), 1'b0);
            end else begin
                apply("b2b_add", 1'b1, 32'h600 + 32'(i * 4), 32'h20, a, b, 1'b0, 2'b00, 4'h0, 1'b0,
                      a + b, ((a + b) == 32'h0), 1'b0);
            end
        end
    endtask

    initial begin
        resetDP = 1'b0;
        pcIn    = '0;
        immIn   = '0;
        rs1Data = '0;
        rs2Data = '0;
        aluSrc  = 1'b0;
        aluOp   = 2'b00;
        f3f7    = 4'h0;
        branch  = 1'b0;
        #2;

        test_reset();
        test_rtype_add_sub();
        test_logic_shift();
        test_itype();
        test_branch();
        test_slt_wrap();
        test_back_to_back();

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clockDP);
            #2;
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL drain scoreboard entries left %0d expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
